// File: rtl/marker_locate_pkg.sv
// Shared types and default geometry for the marker locator and its row detector.
package marker_locate_pkg;

   localparam int DEF_SCREEN_WIDTH  = 1024;
   localparam int DEF_SCREEN_HEIGHT = 768;
   localparam int DEF_MAX_WIDTH     = 100;

   // Run tracker states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IN_RUN = 2'd1,
      GAP    = 2'd2
   } run_state_t;

endpackage

// File: rtl/marker_locate_if.sv
// Detection input bus and frame-result output bus of the marker locator.
interface marker_locate_if #(
   parameter int SCREEN_WIDTH  = marker_locate_pkg::DEF_SCREEN_WIDTH,
   parameter int SCREEN_HEIGHT = marker_locate_pkg::DEF_SCREEN_HEIGHT,
   parameter int MAX_WIDTH     = marker_locate_pkg::DEF_MAX_WIDTH
) ();

   localparam int XW = $clog2(SCREEN_WIDTH) + 1;
   localparam int YW = $clog2(SCREEN_HEIGHT) + 1;
   localparam int WW = $clog2(MAX_WIDTH) + 1;

   logic [XW-1:0] hcount_in;
   logic [YW-1:0] vcount_in;
   logic          done_in;
   logic [XW-1:0] coord_in;
   logic [WW-1:0] centre_width_in;
   logic [10:0]   nt_prob_in;
   logic [XW-1:0] target_x_out;
   logic [YW-1:0] target_y_out;
   logic [7:0]    target_rows_out;
   logic          target_valid_out;

   // Source side: pixel timing plus row-detector results
   modport master (
      output hcount_in, vcount_in, done_in, coord_in, centre_width_in, nt_prob_in,
      input  target_x_out, target_y_out, target_rows_out, target_valid_out
   );

   // Locator side
   modport slave (
      input  hcount_in, vcount_in, done_in, coord_in, centre_width_in, nt_prob_in,
      output target_x_out, target_y_out, target_rows_out, target_valid_out
   );

endinterface

// File: rtl/marker_row_select.sv
// Per-row capture of the lowest-score detection and the end-of-row commit strobe.
// The candidate outputs already merge a detection arriving on the commit cycle.
module marker_row_select #(
   parameter int SCREEN_WIDTH  = marker_locate_pkg::DEF_SCREEN_WIDTH,
   parameter int SCREEN_HEIGHT = marker_locate_pkg::DEF_SCREEN_HEIGHT,
   parameter int MAX_WIDTH     = marker_locate_pkg::DEF_MAX_WIDTH,
   parameter int NT_THRES      = 200
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [$clog2(SCREEN_WIDTH):0]   hcount_i,
   input  logic [$clog2(SCREEN_HEIGHT):0]  vcount_i,
   input  logic                            done_i,
   input  logic [$clog2(SCREEN_WIDTH):0]   coord_i,
   input  logic [$clog2(MAX_WIDTH):0]      width_i,
   input  logic [10:0]                     nt_i,
   output logic                            commit_o,
   output logic                            cand_valid_o,
   output logic [$clog2(SCREEN_WIDTH):0]   cand_coord_o,
   output logic [$clog2(MAX_WIDTH):0]      cand_width_o
);

   localparam int XW = $clog2(SCREEN_WIDTH) + 1;
   localparam int YW = $clog2(SCREEN_HEIGHT) + 1;
   localparam int WW = $clog2(MAX_WIDTH) + 1;

   logic          have_q;
   logic [10:0]   nt_q;
   logic [XW-1:0] coord_q;
   logic [WW-1:0] width_q;

   logic in_range;
   logic accept;
   logic better;

   assign in_range = (hcount_i < XW'(SCREEN_WIDTH)) && (vcount_i < YW'(SCREEN_HEIGHT));
   assign accept   = done_i && in_range && (nt_i <= 11'(NT_THRES));
   // strict compare keeps the earlier detection on equal scores
   assign better   = accept && (!have_q || (nt_i < nt_q));
   assign commit_o = in_range && (hcount_i == XW'(SCREEN_WIDTH - 1));

   assign cand_valid_o = have_q || accept;
   assign cand_coord_o = better ? coord_i : coord_q;
   assign cand_width_o = better ? width_i : width_q;

   // Hold the best detection of the current row; clear after each commit
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         have_q  <= 1'b0;
         nt_q    <= '0;
         coord_q <= '0;
         width_q <= '0;
      end else if (commit_o) begin
         have_q  <= 1'b0;
         nt_q    <= '0;
         coord_q <= '0;
         width_q <= '0;
      end else if (better) begin
         have_q  <= 1'b1;
         nt_q    <= nt_i;
         coord_q <= coord_i;
         width_q <= width_i;
      end
   end

endmodule

// File: rtl/marker_locate.sv
// Tracks vertical runs of row detections and reports the longest valid run per frame.
module marker_locate
   import marker_locate_pkg::*;
#(
   parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
   parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
   parameter int MAX_WIDTH     = DEF_MAX_WIDTH,
   parameter int NT_THRES      = 200,
   parameter int X_TOL         = 8,
   parameter int MIN_ROWS      = 6,
   parameter int MAX_GAP       = 2
) (
   input  logic            clk_in,
   input  logic            rst_in,
   marker_locate_if.slave  bus
);

   localparam int XW = $clog2(SCREEN_WIDTH) + 1;
   localparam int YW = $clog2(SCREEN_HEIGHT) + 1;
   localparam int WW = $clog2(MAX_WIDTH) + 1;
   localparam int GW = $clog2(MAX_GAP + 2) + 1;

   localparam logic [XW-1:0] XTOL_L = XW'(X_TOL);
   localparam logic [GW-1:0] MGAP_L = GW'(MAX_GAP);
   localparam logic [7:0]    MINR_L = 8'(MIN_ROWS);

   logic          commit;
   logic          cand_v;
   logic [XW-1:0] cand_c;
   logic [WW-1:0] cand_w;

   marker_row_select #(
      .SCREEN_WIDTH  (SCREEN_WIDTH),
      .SCREEN_HEIGHT (SCREEN_HEIGHT),
      .MAX_WIDTH     (MAX_WIDTH),
      .NT_THRES      (NT_THRES)
   ) u_row (
      .clk_i        (clk_in),
      .rst_i        (rst_in),
      .hcount_i     (bus.hcount_in),
      .vcount_i     (bus.vcount_in),
      .done_i       (bus.done_in),
      .coord_i      (bus.coord_in),
      .width_i      (bus.centre_width_in),
      .nt_i         (bus.nt_prob_in),
      .commit_o     (commit),
      .cand_valid_o (cand_v),
      .cand_coord_o (cand_c),
      .cand_width_o (cand_w)
   );

   run_state_t    state_q, state_d;
   logic [XW-1:0] run_x_q, run_x_d;
   logic [7:0]    run_len_q, run_len_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [WW-1:0] best_w_q, best_w_d;
   logic [XW-1:0] best_x_q, best_x_d;
   logic [YW-1:0] best_y_q, best_y_d;
   logic [7:0]    fb_len_q, fb_len_d;
   logic [XW-1:0] fb_x_q, fb_x_d;
   logic [YW-1:0] fb_y_q, fb_y_d;
   logic [XW-1:0] tx_q, tx_d;
   logic [YW-1:0] ty_q, ty_d;
   logic [7:0]    tr_q, tr_d;
   logic          tv_q, tv_d;

   logic          last_row;
   logic [XW-1:0] diff;
   logic          match;
   logic [GW-1:0] gap_inc;
   logic          close_row;
   logic [7:0]    fb1_len, fb2_len;
   logic [XW-1:0] fb1_x, fb2_x;
   logic [YW-1:0] fb1_y, fb2_y;

   assign last_row = (bus.vcount_in == YW'(SCREEN_HEIGHT - 1));
   assign diff     = (cand_c >= run_x_q) ? (cand_c - run_x_q) : (run_x_q - cand_c);
   assign match    = cand_v && (diff <= XTOL_L);
   assign gap_inc  = gap_q + GW'(1);

   // Row-level run update, then run close / frame-end resolution.
   // A run closed by a gap and a run still open at frame end are judged
   // in that order, so a restart on the last row is also considered.
   always_comb begin
      state_d   = state_q;
      run_x_d   = run_x_q;
      run_len_d = run_len_q;
      gap_d     = gap_q;
      best_w_d  = best_w_q;
      best_x_d  = best_x_q;
      best_y_d  = best_y_q;
      tx_d      = tx_q;
      ty_d      = ty_q;
      tr_d      = tr_q;
      tv_d      = 1'b0;
      close_row = 1'b0;

      if (commit) begin
         case (state_q)
            IDLE: begin
               if (cand_v) begin
                  state_d   = IN_RUN;
                  run_x_d   = cand_c;
                  run_len_d = 8'd1;
                  gap_d     = '0;
                  best_w_d  = cand_w;
                  best_x_d  = cand_c;
                  best_y_d  = bus.vcount_in;
               end
            end
            IN_RUN, GAP: begin
               if (match) begin
                  state_d   = IN_RUN;
                  run_len_d = (run_len_q == 8'hFF) ? 8'hFF : run_len_q + 8'd1;
                  run_x_d   = cand_c;
                  gap_d     = '0;
                  if (cand_w > best_w_q) begin
                     best_w_d = cand_w;
                     best_x_d = cand_c;
                     best_y_d = bus.vcount_in;
                  end
               end else begin
                  state_d = GAP;
                  gap_d   = gap_inc;
                  if (gap_inc > MGAP_L) begin
                     close_row = 1'b1;
                     if (cand_v) begin
                        state_d   = IN_RUN;
                        run_x_d   = cand_c;
                        run_len_d = 8'd1;
                        gap_d     = '0;
                        best_w_d  = cand_w;
                        best_x_d  = cand_c;
                        best_y_d  = bus.vcount_in;
                     end else begin
                        state_d   = IDLE;
                        run_len_d = '0;
                        gap_d     = '0;
                     end
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      fb1_len = fb_len_q;
      fb1_x   = fb_x_q;
      fb1_y   = fb_y_q;
      if (close_row && (run_len_q >= MINR_L) && (run_len_q > fb_len_q)) begin
         fb1_len = run_len_q;
         fb1_x   = best_x_q;
         fb1_y   = best_y_q;
      end

      fb2_len = fb1_len;
      fb2_x   = fb1_x;
      fb2_y   = fb1_y;
      if ((state_d != IDLE) && (run_len_d >= MINR_L) && (run_len_d > fb1_len)) begin
         fb2_len = run_len_d;
         fb2_x   = best_x_d;
         fb2_y   = best_y_d;
      end

      fb_len_d = fb1_len;
      fb_x_d   = fb1_x;
      fb_y_d   = fb1_y;

      if (commit && last_row) begin
         if (fb2_len != 8'd0) begin
            tx_d = fb2_x;
            ty_d = fb2_y;
            tr_d = fb2_len;
            tv_d = 1'b1;
         end
         fb_len_d  = '0;
         fb_x_d    = '0;
         fb_y_d    = '0;
         state_d   = IDLE;
         run_x_d   = '0;
         run_len_d = '0;
         gap_d     = '0;
         best_w_d  = '0;
         best_x_d  = '0;
         best_y_d  = '0;
      end
   end

   // State, run and result registers
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q   <= IDLE;
         run_x_q   <= '0;
         run_len_q <= '0;
         gap_q     <= '0;
         best_w_q  <= '0;
         best_x_q  <= '0;
         best_y_q  <= '0;
         fb_len_q  <= '0;
         fb_x_q    <= '0;
         fb_y_q    <= '0;
         tx_q      <= '0;
         ty_q      <= '0;
         tr_q      <= '0;
         tv_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_x_q   <= run_x_d;
         run_len_q <= run_len_d;
         gap_q     <= gap_d;
         best_w_q  <= best_w_d;
         best_x_q  <= best_x_d;
         best_y_q  <= best_y_d;
         fb_len_q  <= fb_len_d;
         fb_x_q    <= fb_x_d;
         fb_y_q    <= fb_y_d;
         tx_q      <= tx_d;
         ty_q      <= ty_d;
         tr_q      <= tr_d;
         tv_q      <= tv_d;
      end
   end

   assign bus.target_x_out     = tx_q;
   assign bus.target_y_out     = ty_q;
   assign bus.target_rows_out  = tr_q;
   assign bus.target_valid_out = tv_q;

endmodule
